// File: rtl/if_id_buffer_if.sv
// Fetch/decode-facing signal bundle for the IF/ID instruction queue.
// Handshake: an entry moves fetch->queue on a clock edge where inst_valid=1 and full=0
// (and no flush/halt); it moves queue->decode on an edge where valid_out=1 and stall=0
// (and no flush). full and valid_out are registered, so neither side sees a comb path.
interface if_id_buffer_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   inst_in;
    logic [15:0]   pc_inc_in;
    logic          inst_valid;
    logic          flush;
    logic          stall;
    logic [15:0]   inst_out;
    logic [15:0]   pc_inc_out;
    logic          valid_out;
    logic          full;
    logic          halt_seen;
    logic          err;
    logic [CW-1:0] count;

    modport master (
        output inst_in, pc_inc_in, inst_valid, flush, stall,
        input  inst_out, pc_inc_out, valid_out, full, halt_seen, err, count
    );

    modport slave (
        input  inst_in, pc_inc_in, inst_valid, flush, stall,
        output inst_out, pc_inc_out, valid_out, full, halt_seen, err, count
    );
endinterface

// File: rtl/if_id_buffer.sv
// First-word-fall-through instruction queue between fetch and decode, with
// flush, halt capture and NOP substitution when empty.
module if_id_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input logic          clk,
    input logic          rst,
    if_id_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          halt_seen;
    logic          err;
    logic          valid;
    logic          full;
    logic          push;
    logic          pop;
    logic          is_halt;

    assign valid   = (count != '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign is_halt = (bus.inst_in[15:11] == 5'b00000);
    assign push    = bus.inst_valid & ~full & ~bus.flush & ~halt_seen;
    assign pop     = valid & ~bus.stall & ~bus.flush;

    // Storage is deliberately not reset; it is only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.inst_in, bus.pc_inc_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            halt_seen <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (bus.inst_valid & full & ~bus.flush & ~halt_seen) begin
                err <= 1'b1;
            end
            if (bus.flush) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                halt_seen <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    if (is_halt) begin
                        halt_seen <= 1'b1;
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + (PW+1)'(1);
                    2'b01:   count <= count - (PW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign bus.inst_out   = valid ? mem[rd_ptr][31:16] : NOP_INST;
    assign bus.pc_inc_out = valid ? mem[rd_ptr][15:0]  : 16'h0000;
    assign bus.valid_out  = valid;
    assign bus.full       = full;
    assign bus.halt_seen  = halt_seen;
    assign bus.err        = err;
    assign bus.count      = count;
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: a driver queues the expected {inst, pc} of each
// accepted push; a monitor pops and compares whenever decode actually consumes an entry.
module tb_if_id_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];

    if_id_buffer_if #(.DEPTH(2)) bus ();

    if_id_buffer #(.DEPTH(2), .NOP_INST(16'h0800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: a pop happens on an edge where valid_out & ~stall & ~flush
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid_out && !bus.stall && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %h/%h expected none", bus.inst_out, bus.pc_inc_out);
                end else begin
                    chk("pop_data", {bus.inst_out, bus.pc_inc_out}, exp_q.pop_front());
                end
            end else if (!bus.valid_out) begin
                chk("empty_nop", {bus.inst_out, bus.pc_inc_out}, {16'h0800, 16'h0000});
            end
        end
    end

    // driver: applies one cycle of inputs, then returns #1 after the consuming edge
    task automatic step(input logic iv, input logic [15:0] inst, input logic [15:0] pc,
                        input logic st, input logic fl, input logic acc);
        bus.inst_valid = iv;
        bus.inst_in    = inst;
        bus.pc_inc_in  = pc;
        bus.stall      = st;
        bus.flush      = fl;
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back({inst, pc});
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [1:0] cnt, input logic fu,
                                input logic er, input logic ht);
        chk({tag, "_count"}, 32'(bus.count), 32'(cnt));
        chk({tag, "_full"},  32'(bus.full),  32'(fu));
        chk({tag, "_err"},   32'(bus.err),   32'(er));
        chk({tag, "_halt"},  32'(bus.halt_seen), 32'(ht));
        chk({tag, "_valid"}, 32'(bus.valid_out), 32'(cnt != 2'd0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.inst_valid = 1'b0;
        bus.inst_in    = 16'h0;
        bus.pc_inc_in  = 16'h0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inst", 32'(bus.inst_out), 32'h0800);
        chk("reset_pc", 32'(bus.pc_inc_out), 32'h0);
        expect_state("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // streaming with no stall: head appears one cycle after push
        step(1'b1, 16'h4123, 16'h0002, 1'b0, 1'b0, 1'b1);
        chk("stream_head", 32'(bus.inst_out), 32'h4123);
        expect_state("stream1", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4567, 16'h0004, 1'b0, 1'b0, 1'b1);
        chk("stream_head2", 32'(bus.inst_out), 32'h4567);
        expect_state("stream2", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        expect_state("stream3", 2'd0, 1'b0, 1'b0, 1'b0);

        // decode stall fills the queue; third push refused and flags err
        step(1'b1, 16'h4a01, 16'h0006, 1'b1, 1'b0, 1'b1);
        expect_state("fill1", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4a02, 16'h0008, 1'b1, 1'b0, 1'b1);
        expect_state("fill2", 2'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h4a03, 16'h000a, 1'b1, 1'b0, 1'b0);
        expect_state("fill3", 2'd2, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        expect_state("drain1", 2'd1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        expect_state("drain2", 2'd0, 1'b0, 1'b1, 1'b0);

        // asynchronous reset mid-operation
        step(1'b1, 16'h4b01, 16'h000c, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h4b02, 16'h000e, 1'b1, 1'b0, 1'b1);
        bus.inst_valid = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_inst", 32'(bus.inst_out), 32'h0800);
        chk("async_rst_pc", 32'(bus.pc_inc_out), 32'h0);
        expect_state("async_rst", 2'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // flush with inst_valid=1 discards queue and the flush-cycle instruction
        step(1'b1, 16'h5001, 16'h0010, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h5002, 16'h0012, 1'b1, 1'b0, 1'b1);
        expect_state("pre_flush", 2'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h5003, 16'h0014, 1'b1, 1'b1, 1'b0);
        chk("flush_inst", 32'(bus.inst_out), 32'h0800);
        expect_state("flush", 2'd0, 1'b0, 1'b0, 1'b0);

        // halt capture, refusal, drain, then flush re-enables pushes
        step(1'b1, 16'h0000, 16'h0016, 1'b0, 1'b0, 1'b1);
        chk("halt_head", 32'(bus.inst_out), 32'h0000);
        expect_state("halt1", 2'd1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h4123, 16'h0018, 1'b0, 1'b0, 1'b0);
        expect_state("halt2", 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        expect_state("halt_flush", 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4124, 16'h001a, 1'b0, 1'b0, 1'b1);
        expect_state("post_halt", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        expect_state("post_halt2", 2'd0, 1'b0, 1'b0, 1'b0);

        // pointer wrap with toggling stall
        step(1'b1, 16'h6001, 16'h0020, 1'b1, 1'b0, 1'b1);
        expect_state("wrap_a", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h6002, 16'h0022, 1'b0, 1'b0, 1'b1);
        expect_state("wrap_b", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        expect_state("wrap_c", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h6003, 16'h0024, 1'b0, 1'b0, 1'b1);
        expect_state("wrap_d", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h6004, 16'h0026, 1'b1, 1'b0, 1'b1);
        expect_state("wrap_e", 2'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        expect_state("wrap_f", 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        expect_state("wrap_g", 2'd0, 1'b0, 1'b0, 1'b0);

        repeat (2) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Two-entry first-word-fall-through instruction queue between the fetch stage and the decode stage.
- Fetch pushes each returned instruction together with its incremented PC. Decode pops from the queue head.
- A fetch stall (cache miss) or a decode stall (hazard) therefore no longer freezes the other stage.
- Handles branch/jump flush, halt capture, and NOP (16'h0800) insertion when no valid instruction is available.

Parameters:
- DEPTH, 2: number of entries; must be a power of two, 2..8.
- NOP_INST, 16'h0800: instruction driven to decode when the queue is empty.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_in  in  16  instruction from fetch.
- pc_inc_in  in  16  PC+2 associated with inst_in.
- inst_valid  in  1  fetch has a valid instruction this cycle (cache hit, not a flushed slot).
- flush  in  1  branch/jump taken in a later stage; discard all queued instructions.
- stall  in  1  decode cannot accept an instruction this cycle (hazard).
- inst_out  out  16  head instruction, or NOP_INST when empty.
- pc_inc_out  out  16  head PC+2, or 16'h0000 when empty.
- valid_out  out  1  head entry is valid.
- full  out  1  queue holds DEPTH entries; fetch must hold its PC.
- halt_seen  out  1  a halt instruction (opcode inst[15:11]==5'b00000) has been accepted.
- err  out  1  sticky protocol error.

Behaviour:
- State:
  - Storage array of DEPTH x 32 bits (inst and pc_inc).
  - rd_ptr and wr_ptr, log2(DEPTH) bits each, wrapping modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
  - halt_seen and err flags.
- Reset (asynchronous, active-high): count=0, pointers=0, halt_seen=0, err=0. While in reset, outputs are inst_out=NOP_INST, pc_inc_out=0, valid_out=0, full=0.
- Storage array contents are not reset; they are never observable while count=0.
- Outputs are combinational from registered state only; there is no input-to-output path.
  - valid_out = (count!=0).
  - full = (count==DEPTH).
  - inst_out and pc_inc_out are the head entry, or NOP_INST / 0 when empty.
- push = inst_valid & ~full & ~flush & ~halt_seen.
  - On push, write {inst_in, pc_inc_in} at wr_ptr and increment wr_ptr.
- pop = valid_out & ~stall & ~flush.
  - On pop, increment rd_ptr.
  - Latency: an instruction pushed in cycle N appears at the head in cycle N+1 when the queue was empty.
- count update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - both or neither: unchanged.
  - When not full and not empty, a simultaneous push and pop keeps count constant and advances both pointers.
- Full boundary:
  - push is blocked.
  - A pop in the same cycle frees one slot, but the push is still refused because full is registered.
  - Fetch retries next cycle.
- Empty boundary:
  - No pop occurs.
  - A push in the same cycle lands in storage; decode sees it the next cycle.
- flush (highest priority after reset):
  - Next edge: count=0, rd_ptr=wr_ptr=0, halt_seen=0.
  - Same-cycle push and pop are both suppressed.
  - In the flush cycle itself, outputs still reflect the pre-flush state; decode must ignore them because flush also squashes decode.
- Halt:
  - When a pushed inst_in has inst_in[15:11]==5'b00000, halt_seen sets on that edge.
  - All further pushes are refused until flush or reset.
  - Already-queued instructions continue to drain normally.
- err:
  - Sets when inst_valid & full & ~flush & ~halt_seen, i.e. fetch presents a new instruction without honouring full.
  - Stays set until reset.
  - Does not alter queue contents.
- Pointer wrap: at DEPTH-1, a pointer increments to 0. With DEPTH=2 the pointers are 1 bit and alternate.

Test Plan:
- Reset mid-operation: push 2 entries, assert rst asynchronously between edges -> outputs immediately NOP 16'h0800, pc_inc_out=0, valid_out=0, full=0, err=0.
- Streaming: stall=0, push 16'h4123/pc 16'h0002, then 16'h4567/16'h0004 on consecutive cycles -> inst_out shows 4123 one cycle after its push, then 4567; count never exceeds 1.
- Decode stall fill: stall=1, push 3 valid instructions -> full=1 after 2; 3rd refused and err=1 (sticky); release stall -> entries emerge in order and full clears after the first pop.
- Flush: 2 entries queued, assert flush with inst_valid=1 -> next cycle valid_out=0, inst_out=16'h0800; the flush-cycle instruction is not stored.
- Halt: push 16'h0000 then 16'h4123 -> halt_seen=1, second push refused, 0000 drains; flush -> halt_seen=0 and pushes accepted again.
- Wrap-around: 6 alternating push/pop cycles with stall toggling -> data order preserved across pointer wrap; count matches a reference model every cycle.
